cntr8_dn: RTL and testbench
===========================

// Module: cntr8_dn
// PURPOSE
//  Loadable 8-bit down-counter; counterpart to the up-counter in the counter/shifter/register-file block.
//  Decrement datapath: 4-bit borrow look-ahead slices (bla4), rippled slice-to-slice.
//  Per bit: generate Gi = ~a & b, propagate Pi = ~(a ^ b).
//  A 4-state FSM selects hold / load / decrement-by-1 / decrement-by-2.
//  Feeds the register-file address sequencer and the shifter repeat count.
// PARAMETERS
//  WIDTH  8  counter width; must be a multiple of 4 (one bla4 slice per nibble)
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      synchronous, active-high reset
//  load    in   1      load d_in (highest priority)
//  dec     in   1      decrement request
//  d_in    in   WIDTH  load value
//  o       out  WIDTH  registered count
//  state   out  2      registered FSM state
//  zero    out  1      combinational, (o == 0)
//  uf      out  1      registered underflow pulse, one cycle
// BEHAVIOUR
//  - Reset (clk edge with reset=1): state=IDLE(00), o=0, uf=0; zero=1 follows.
//  - Reset has priority over load/dec, including mid-DEC2.
//  - States: IDLE=00 hold, LOAD=01 o<=d_in, DEC=10 o<=o-1, DEC2=11 o<=o-2.
//  - Transitions, evaluated every edge (load has priority over dec in all states):
//      - any state, load=1            -> LOAD
//      - IDLE/LOAD, load=0, dec=1     -> DEC
//      - DEC/DEC2,  load=0, dec=1     -> DEC2 (sustained dec accelerates)
//      - any state, load=0, dec=0     -> IDLE
//  - Datapath update:
//      - o is updated on the same edge as state, from next_state (not the current state).
//      - Latency: load/dec sampled at edge n -> o reflects it after edge n.
//  - Arithmetic:
//      - o_next = o - step, step = 1 (DEC) or 2 (DEC2).
//      - Modulo 2^WIDTH; borrow-in = 0; step zero-extended to WIDTH.
//      - Final slice borrow-out = underflow.
//  - uf:
//      - Set to 1 on the edge where the decrement borrows out (o < step).
//      - Otherwise 0, including on LOAD and IDLE edges.
//  - Wrap: o=0 + DEC -> FF, uf=1. o=1 + DEC2 -> FF, uf=1. o=0 + DEC2 -> FE, uf=1.
//  - load and dec together: load wins; dec is ignored for that edge; uf=0.
//  - IDLE holds o indefinitely. zero is purely combinational from o.
// CONFIGURATION
//  CNTR8_DN_SAT_EN defined:
//    - Decrement saturates at 0 instead of wrapping; o=1 + DEC2 -> 0.
//    - uf still pulses on every saturating edge.
//    - FSM transitions are unchanged.
//  CNTR8_DN_SAT_EN undefined: modulo wrap as above (default build).
// TESTING
//  1. reset=1 for 2 cycles with load=1, d_in=5A -> o=00, state=00, zero=1, uf=0.
//  2. load d_in=03, then dec held 3 cycles:
//       -> o = 03, 02, 00, FE; state = 01, 10, 11, 11; uf=1 on the FE edge only.
//  3. o=00, dec 1 cycle -> o=FF, uf=1, state=10; next edge dec=0 -> state=00, o=FF, uf=0.
//  4. load=1 and dec=1, d_in=80, from DEC2 -> state=01, o=80, uf=0.
//  5. In DEC2 at o=40, assert reset -> next edge o=00, state=00, uf=0.
//  6. CNTR8_DN_SAT_EN build:
//       - o=01 + DEC2 -> o=00, uf=1.
//       - dec held further -> o stays 00, uf=1 each edge, zero=1.

Source files
------------

// File: rtl/cntr8_dn.sv
// ----------------------------------------------------------------------------
// cntr8_dn : loadable down-counter (default WIDTH = 8)
//
// Decrements through borrow look-ahead nibble slices (bla4) that ripple
// borrow from slice to slice. A 4-state FSM selects hold, load,
// decrement-by-1 or decrement-by-2. Holding dec for consecutive edges
// moves the FSM to DEC2, so the count speeds up.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high reset (highest priority)
//   load   in   1      load d_in (wins over dec)
//   dec    in   1      decrement request
//   d_in   in   WIDTH  load value
//   o      out  WIDTH  registered count
//   state  out  2      registered FSM state (IDLE=00 LOAD=01 DEC=10 DEC2=11)
//   zero   out  1      combinational, high when o == 0
//   uf     out  1      registered one-cycle underflow pulse
//
// Build option
//   CNTR8_DN_SAT_EN : when defined, the count saturates at zero instead of
//                     wrapping. uf still pulses on every saturating edge.
//
// WIDTH must be a multiple of 4 because each bla4 slice covers one nibble.
// ----------------------------------------------------------------------------
module cntr8_dn #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] o,
    output logic [1:0]       state,
    output logic             zero,
    output logic             uf
);

    localparam int unsigned NSLICE = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_DEC  = 2'b10,
        S_DEC2 = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [WIDTH-1:0] r_o;
    logic             r_uf;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_bin;
    logic [4:0]       w_slice;

    // One 4-bit borrow look-ahead slice that computes a - b - bin.
    // Returns {borrow_out, diff[3:0]}.
    // Per bit: generate g = ~a & b, propagate p = ~(a ^ b).
    function automatic logic [4:0] bla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       bin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = ~a & b;
        p    = ~(a ^ b);
        c[0] = bin;
        c[1] = g[0] | (p[0] & bin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & bin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & bin);
        return {c[4], a ^ b ^ c[3:0]};
    endfunction

    // Next-state logic. load beats dec. A sustained dec from DEC or DEC2
    // moves to DEC2.
    always_comb begin
        w_nxt_state = S_IDLE;
        if (load) begin
            w_nxt_state = S_LOAD;
        end else if (dec) begin
            if (r_state == S_DEC || r_state == S_DEC2)
                w_nxt_state = S_DEC2;
            else
                w_nxt_state = S_DEC;
        end
    end

    // The step follows next_state, so the datapath and the FSM move on the
    // same edge.
    always_comb begin
        w_step      = '0;
        w_step[1:0] = (w_nxt_state == S_DEC2) ? 2'd2 : 2'd1;
    end

    // Ripple the borrow between the nibble slices. Borrow-in to slice 0 is 0.
    always_comb begin
        w_diff  = '0;
        w_bin   = 1'b0;
        w_slice = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            w_slice           = bla4(r_o[4*i +: 4], w_step[4*i +: 4], w_bin);
            w_diff[4*i +: 4]  = w_slice[3:0];
            w_bin             = w_slice[4];
        end
        w_borrow = w_bin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_o     <= '0;
            r_uf    <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_uf    <= 1'b0;
            case (w_nxt_state)
                S_LOAD: r_o <= d_in;
                S_DEC, S_DEC2: begin
                    r_uf <= w_borrow;
`ifdef CNTR8_DN_SAT_EN
                    r_o  <= w_borrow ? '0 : w_diff;
`else
                    r_o  <= w_diff;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o     = r_o;
    assign state = r_state;
    assign zero  = (r_o == '0);
    assign uf    = r_uf;

endmodule

// File: tb/tb_cntr8_dn.sv
// ----------------------------------------------------------------------------
// tb_cntr8_dn : self-checking bench for cntr8_dn (WIDTH = 8).
//
// The bench first applies a table of directed vectors, one row per clock
// edge. It then runs a randomized phase and compares the DUT against an
// integer model of the counting rules.
// Define CNTR8_DN_SAT_EN for both the RTL and the bench to check the
// saturating build.
// ----------------------------------------------------------------------------
module tb_cntr8_dn;

`ifdef CNTR8_DN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       load;
    logic       dec;
    logic [7:0] d_in;
    logic [7:0] o;
    logic [1:0] state;
    logic       zero;
    logic       uf;

    int n_pass  = 0;
    int n_total = 0;

    cntr8_dn #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .dec   (dec),
        .d_in  (d_in),
        .o     (o),
        .state (state),
        .zero  (zero),
        .uf    (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic       dc;
        logic [7:0] d;
        logic [7:0] eo;
        logic [1:0] es;
        logic       euf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic ld, input logic dc,
                                input logic [7:0] d, input logic [7:0] eo,
                                input logic [1:0] es, input logic euf);
        vec_t v;
        v.rst = rst; v.ld = ld; v.dc = dc; v.d = d;
        v.eo = eo; v.es = es; v.euf = euf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s [%0d]: actual %0h required %0h", name, idx, act, exp);
    endtask

    // Drive one edge, then sample 1 ns after the edge.
    task automatic apply(input logic rst, input logic ld, input logic dc, input logic [7:0] d);
        reset = rst; load = ld; dec = dc; d_in = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: plain integers.
    int m_o, m_st, m_uf;

    task automatic model_step(input logic rst, input logic ld, input logic dc, input int d);
        int step;
        if (rst) begin
            m_o = 0; m_st = 0; m_uf = 0;
        end else if (ld) begin
            m_o = d; m_st = 1; m_uf = 0;
        end else if (dc) begin
            m_st = (m_st >= 2) ? 3 : 2;
            step = (m_st == 3) ? 2 : 1;
            if (m_o < step) begin
                m_uf = 1;
                m_o  = SAT ? 0 : m_o + 256 - step;
            end else begin
                m_uf = 0;
                m_o  = m_o - step;
            end
        end else begin
            m_st = 0; m_uf = 0;
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; dec = 1'b0; d_in = '0;

        // Reset with load asserted.
        add(1, 1, 0, 8'h5A, 8'h00, 2'd0, 0);
        add(1, 1, 0, 8'h5A, 8'h00, 2'd0, 0);
        // Load 03, then hold dec for 3 edges.
        add(0, 1, 0, 8'h03, 8'h03, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'h02, 2'd2, 0);
        add(0, 0, 1, 8'h00, 8'h00, 2'd3, 0);
        add(0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFE, 2'd3, 1);
        // o = 00, one dec, then release.
        add(0, 1, 0, 8'h00, 8'h00, 2'd1, 0);
        add(0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFF, 2'd2, 1);
        add(0, 0, 0, 8'h00, SAT ? 8'h00 : 8'hFF, 2'd0, 0);
        add(0, 0, 0, 8'h00, SAT ? 8'h00 : 8'hFF, 2'd0, 0);
        // Load and dec together while in DEC2: load wins.
        add(0, 1, 0, 8'h10, 8'h10, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'h0F, 2'd2, 0);
        add(0, 0, 1, 8'h00, 8'h0D, 2'd3, 0);
        add(0, 1, 1, 8'h80, 8'h80, 2'd1, 0);
        // Reset during DEC2 at o = 40.
        add(0, 1, 0, 8'h43, 8'h43, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'h42, 2'd2, 0);
        add(0, 0, 1, 8'h00, 8'h40, 2'd3, 0);
        add(1, 0, 1, 8'h00, 8'h00, 2'd0, 0);
        // o = 01 with DEC2, then keep decrementing.
        add(0, 1, 0, 8'h02, 8'h02, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'h01, 2'd2, 0);
        add(0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFF, 2'd3, 1);
        add(0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFD, 2'd3, SAT);
        add(0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFB, 2'd3, SAT);
        // o = 00 with DEC2.
        add(0, 1, 0, 8'h01, 8'h01, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'h00, 2'd2, 0);
        add(0, 0, 1, 8'h00, SAT ? 8'h00 : 8'hFE, 2'd3, 1);
        add(0, 0, 0, 8'h00, SAT ? 8'h00 : 8'hFE, 2'd0, 0);
        // Top of range: no borrow out of the upper slice.
        add(0, 1, 0, 8'hFF, 8'hFF, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'hFE, 2'd2, 0);
        add(0, 0, 1, 8'h00, 8'hFC, 2'd3, 0);
        // Borrow across the nibble boundary.
        add(0, 1, 0, 8'h11, 8'h11, 2'd1, 0);
        add(0, 0, 1, 8'h00, 8'h10, 2'd2, 0);
        add(0, 0, 1, 8'h00, 8'h0E, 2'd3, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ld, vecs[i].dc, vecs[i].d);
            chk("vec_o",     i, int'(o),     int'(vecs[i].eo));
            chk("vec_state", i, int'(state), int'(vecs[i].es));
            chk("vec_zero",  i, int'(zero),  (vecs[i].eo == 8'h00) ? 1 : 0);
            chk("vec_uf",    i, int'(uf),    int'(vecs[i].euf));
        end

        // Randomized phase. A reset first puts the model and the DUT in step.
        m_o = 0; m_st = 0; m_uf = 0;
        apply(1, 0, 0, 8'h00);
        model_step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst, r_ld, r_dc;
            logic [7:0] r_d;
            r_rst = ($urandom_range(0, 63) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_dc  = ($urandom_range(0, 3) != 0);
            r_d   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3))
                                                : 8'($urandom);
            apply(r_rst, r_ld, r_dc, r_d);
            model_step(r_rst, r_ld, r_dc, int'(r_d));
            chk("rnd_o",     i, int'(o),     m_o);
            chk("rnd_state", i, int'(state), m_st);
            chk("rnd_zero",  i, int'(zero),  (m_o == 0) ? 1 : 0);
            chk("rnd_uf",    i, int'(uf),    m_uf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
